layer_text_writer: RTL
======================

# layer_text_writer

Serializes an 8-bit feature map, such as the 14x14 layer-1 map held in the layer display RAM, into a stream of ASCII decimal text bytes for export over the SD/UART byte path. It is the encoder counterpart of the SD pixel loader: the loader turns whitespace-separated decimal text into pixel values, and this block turns stored values back into that text. It sits between a RAM read port and a byte sink with a valid/ready handshake, and is controlled by a start/busy/done interface.

## Interface
- `WIDTH`, 14: values per row. A newline follows the last value of each row.
- `HEIGHT`, 14: number of rows.
- `ADDR_W`, 12: RAM address width. Requires WIDTH*HEIGHT ≤ 2^ADDR_W.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a dump. Sampled only in IDLE.
- `busy`  out  1  high while a dump is in progress.
- `done`  out  1  one-cycle pulse after the final byte is accepted.
- `raddr`  out  ADDR_W  RAM read address (registered).
- `rdata`  in  8  RAM read data. Synchronous RAM: data for `raddr` is valid one clock after `raddr` changes.
- `out_valid`  out  1  `out_byte` holds a byte to send.
- `out_ready`  in  1  the sink accepts the byte when `out_valid && out_ready` at a rising edge.
- `out_byte`  out  8  ASCII byte.

## Operation
- **Scan order:** addresses 0 .. WIDTH*HEIGHT-1, row-major. Column counter `col` runs 0..WIDTH-1.
- **States:**
  - IDLE: `start` → FETCH0, with `raddr`=0, `col`=0, `busy`=1.
  - FETCH0: one wait cycle → FETCH1.
  - FETCH1: latch `rdata` into `val`; compute hundreds, tens and ones digits → EMIT.
  - EMIT: send the digits with leading zeros suppressed. 0 sends "0"; 7 sends "7"; 10 sends "10"; 100 sends "100"; 255 sends "255".
  - SEP: send the separator.
    - If `col`≠WIDTH-1: send 0x20 (space).
    - If `col`=WIDTH-1: send 0x0A (newline).
    - On acceptance, if this was not the last address: increment `raddr`, wrap or increment `col`, go to FETCH0.
    - On acceptance of the last address's newline: go to DONE.
  - DONE: `done`=1 and `busy`=0 for one cycle → IDLE.
- **Digit arithmetic:**
  - Hundreds is 2 if `val`≥200, 1 if `val`≥100, else 0.
  - Tens and ones are derived from the remainder (below 100) by comparison against multiples of 10.
  - No divider is used. ASCII code = 0x30 + digit.
- **Byte counts:**
  - Per value: digit count (1–3) plus 1 separator.
  - Total per dump: sum of the digit counts plus WIDTH*HEIGHT. For an all-zero 14x14 map this is 392 bytes.
- **Ignored input:** `start` is ignored while `busy`=1.

## Timing
- **Reset values:** `busy`=0, `done`=0, `out_valid`=0, `out_byte`=0x00, `raddr`=0. State = IDLE.
- **Reset mid-dump:** reset takes effect immediately and aborts the stream. No `done` pulse; no partial byte remains valid after reset deasserts.
- **Start latency:** with the `start` edge counted as edge 0, `out_valid` first rises after edge 2.
- **Handshake:**
  - Once asserted, `out_valid` and `out_byte` stay stable until accepted.
  - `out_valid` never drops without acceptance, except on reset.
  - `out_ready` stalls of any length are allowed. `out_ready` may be high before `out_valid`.
- **Throughput with `out_ready`=1:**
  - One byte per clock within a value.
  - `out_valid`=0 for exactly 2 clocks between values (FETCH0, FETCH1).
- **`raddr` stability:** `raddr` changes only on acceptance of the separator byte, so it is stable throughout EMIT and SEP.
- **`done` timing:** `done` rises the clock after the final newline is accepted.
- **Start after done:** `start` held high through the DONE cycle is seen in the following IDLE cycle. The next dump then begins one clock after IDLE.
- **`busy` window:** high from the edge after `start` is accepted up to, but not including, the DONE cycle.

## Test plan
- **All-zero map:** 14x14 map of zeros, `out_ready`=1.
  - Expect 392 bytes: pattern "0 " repeated, with "0\n" at every 14th value.
  - `done` pulses once; `busy` is low afterwards.
- **Digit formatting:** values 0, 7, 10, 99, 100, 199, 200, 255 at addresses 0–7, remainder zero.
  - The stream begins with "0 7 10 99 100 199 200 255 0 …" in ASCII.
- **Backpressure:** toggle `out_ready` randomly at 30% duty on the all-255 map.
  - Output is exactly "255 " ×13 then "255\n", repeated for each of 14 rows.
  - `out_byte` never changes while `out_valid`=1 and `out_ready`=0.
- **Start latency and row boundary:** with WIDTH=3, HEIGHT=2 and values 1..6, pulse `start`.
  - `out_valid` rises after edge 2.
  - Full stream is "1 2 3\n4 5 6\n" (12 bytes).
  - `raddr` sequence is 0..5.
- **Reset mid-dump:** assert `rst_n`=0 during the 50th byte.
  - All outputs return to their reset values immediately; no `done` pulse.
  - A new `start` restarts the dump from address 0.
- **Start while busy:** pulse `start` during a dump.
  - No restart; total byte count unchanged; exactly one `done` pulse.

Source files
------------

// File: rtl/layer_text_writer.sv
// layer_text_writer: serializes an 8-bit feature map from a synchronous RAM into
// whitespace-separated ASCII decimal text over a valid/ready byte stream.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   start_i      begin a dump (sampled only when idle)
//   busy_o       high while a dump is in progress
//   done_o       one-cycle pulse after the final newline is accepted
//   raddr_o      registered RAM read address, row-major scan
//   rdata_i      RAM read data, valid one clock after raddr_o changes
//   out_valid_o  out_byte_o holds a byte to send
//   out_ready_i  sink accepts the byte when out_valid_o && out_ready_i at a rising edge
//   out_byte_o   ASCII byte: digits, space between values, newline after each row
module layer_text_writer #(
   parameter int WIDTH  = 14,
   parameter int HEIGHT = 14,
   parameter int ADDR_W = 12
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] raddr_o,
   input  logic [7:0]        rdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [7:0]        out_byte_o
);
   typedef enum logic [2:0] {IDLE, FETCH0, FETCH1, EMIT, SEP, DONE} state_e;
   localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   state_e state_q, state_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [CW-1:0] col_q, col_d;
   // dig_q[2] hundreds, [1] tens, [0] ones; idx_q counts down to the ones digit
   logic [2:0][3:0] dig_q, dig_d;
   logic [1:0] idx_q, idx_d;
   logic accept;
   logic [7:0] rem;
   logic [3:0] hun, ten, one;
   assign accept = out_valid_o && out_ready_i;
   assign raddr_o = raddr_q;
   // Divider-free decimal split: compare against hundreds, then multiples of ten.
   always_comb begin
      hun = rdata_i >= 8'd200 ? 4'd2 : rdata_i >= 8'd100 ? 4'd1 : 4'd0;
      rem = rdata_i - (hun == 4'd2 ? 8'd200 : hun == 4'd1 ? 8'd100 : 8'd0);
      ten = 4'd0;
      for (int k = 1; k < 10; k++) if (rem >= 8'(10 * k)) ten = 4'(k);
      one = 4'(rem - {4'd0, ten} * 8'd10);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         raddr_q <= '0;
         col_q   <= '0;
         dig_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         raddr_q <= raddr_d;
         col_q   <= col_d;
         dig_q   <= dig_d;
         idx_q   <= idx_d;
      end
   end
   always_comb begin
      state_d = state_q;
      raddr_d = raddr_q;
      col_d   = col_q;
      dig_d   = dig_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = FETCH0;
            raddr_d = '0;
            col_d   = '0;
         end
         FETCH0: state_d = FETCH1;
         FETCH1: begin
            state_d = EMIT;
            dig_d   = {hun, ten, one};
            // first digit sent is the most significant non-zero one; 0 itself sends "0"
            idx_d   = hun != 4'd0 ? 2'd2 : ten != 4'd0 ? 2'd1 : 2'd0;
         end
         EMIT: if (accept) begin
            if (idx_q == 2'd0) state_d = SEP;
            else idx_d = idx_q - 2'd1;
         end
         SEP: if (accept) begin
            if (raddr_q == LAST) state_d = DONE;
            else begin
               state_d = FETCH0;
               raddr_d = raddr_q + ADDR_W'(1);
               col_d   = col_q == COL_LAST ? '0 : col_q + CW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      busy_o      = state_q != IDLE && state_q != DONE;
      done_o      = state_q == DONE;
      out_valid_o = state_q == EMIT || state_q == SEP;
      out_byte_o  = state_q == EMIT ? 8'h30 + {4'd0, dig_q[idx_q]} :
                    state_q == SEP  ? (col_q == COL_LAST ? 8'h0A : 8'h20) : 8'h00;
   end
endmodule
